// File: rtl/register_pipeline_collapsing.sv
// Chain of DEPTH handshaked register stages. Empty stages are squeezed out, so a
// stalled output only blocks upstream once every stage ahead is occupied.
module register_pipeline_collapsing #(
    parameter int                    WORD_WIDTH  = 0,
    parameter int                    DEPTH       = 1,
    parameter logic [WORD_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                         clock,
    input  logic                         areset,
    input  logic                         clear,
    input  logic                         input_valid,
    output logic                         input_ready,
    input  logic [WORD_WIDTH-1:0]        input_data,
    output logic                         output_valid,
    input  logic                         output_ready,
    output logic [WORD_WIDTH-1:0]        output_data,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    // Handshake: a word moves across a port on a rising edge exactly when valid
    // and ready are both high in the cycle before it; valid never depends on ready.
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [WORD_WIDTH-1:0] data_q [DEPTH];
    logic [WORD_WIDTH-1:0] data_d [DEPTH];
    logic [OCC_W-1:0]      occupancy_q, occupancy_d;
    logic [DEPTH-1:0]      advance;
    logic                  input_accept;

    // advance[i] is high when some stage at or beyond i is empty, or the output drains.
    always_comb begin
        logic open_path;
        open_path = output_ready;
        advance   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            open_path  = open_path | !valid_q[i];
            advance[i] = open_path;
        end
    end

    assign input_ready  = advance[0] & !clear;
    assign input_accept = input_valid & input_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clear) begin
            valid_d = '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_d[i] = RESET_VALUE;
            end
        end else begin
            if (advance[0]) begin
                valid_d[0] = input_accept;
                if (input_accept) begin
                    data_d[0] = input_data;
                end
            end
            // A bubble moving in clears valid but leaves the stale data in place.
            for (int i = 1; i < DEPTH; i++) begin
                if (advance[i]) begin
                    valid_d[i] = valid_q[i-1];
                    if (valid_q[i-1]) begin
                        data_d[i] = data_q[i-1];
                    end
                end
            end
        end
    end

    always_comb begin
        occupancy_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy_d = occupancy_d + OCC_W'(valid_d[i]);
        end
    end

    always_ff @(posedge clock or posedge areset) begin
        if (areset) begin
            valid_q     <= '0;
            occupancy_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= RESET_VALUE;
            end
        end else begin
            valid_q     <= valid_d;
            occupancy_q <= occupancy_d;
            data_q      <= data_d;
        end
    end

    assign output_valid = valid_q[DEPTH-1];
    assign output_data  = data_q[DEPTH-1];
    assign occupancy    = occupancy_q;

endmodule

// File: tb/tb_register_pipeline_collapsing.sv
// Directed bench for the collapsing register chain (DEPTH=4) plus a randomized
// DEPTH=1 instance checked against an expected-word queue.
module tb_register_pipeline_collapsing;

    logic       clock = 1'b0;
    logic       areset = 1'b0;

    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [2:0] occ;

    logic       clear1 = 1'b0;
    logic       in1_valid = 1'b0;
    logic       in1_ready;
    logic [7:0] in1_data = '0;
    logic       out1_valid;
    logic       out1_ready = 1'b0;
    logic [7:0] out1_data;
    logic [0:0] occ1;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    always #5 clock = ~clock;

    register_pipeline_collapsing #(.WORD_WIDTH(8), .DEPTH(4), .RESET_VALUE(8'hA5)) u_dut (
        .clock(clock), .areset(areset), .clear(clear),
        .input_valid(in_valid), .input_ready(in_ready), .input_data(in_data),
        .output_valid(out_valid), .output_ready(out_ready), .output_data(out_data),
        .occupancy(occ)
    );

    register_pipeline_collapsing #(.WORD_WIDTH(8), .DEPTH(1), .RESET_VALUE(8'hA5)) u_dut1 (
        .clock(clock), .areset(areset), .clear(clear1),
        .input_valid(in1_valid), .input_ready(in1_ready), .input_data(in1_data),
        .output_valid(out1_valid), .output_ready(out1_ready), .output_data(out1_data),
        .occupancy(occ1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        // Reset
        areset = 1'b1;
        #12;
        tick();
        areset = 1'b0;
        settle();
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 8'hA5);
        check("reset_occ", occ, 0);
        check("reset_in_ready", in_ready, 1);
        check("reset_occ_d1", occ1, 0);

        // Streaming 1..10 with output_ready held high
        tick();
        for (int c = 0; c <= 14; c++) begin
            in_valid  = (c < 10);
            in_data   = 8'(c + 1);
            out_ready = 1'b1;
            settle();
            check("stream_out_valid", out_valid, (c >= 4 && c <= 13));
            if (c >= 4 && c <= 13) check("stream_out_data", out_data, c - 3);
            check("stream_occ", occ, (c <= 10) ? ((c < 4) ? c : 4) : 14 - c);
            if (c < 10) check("stream_in_ready", in_ready, 1);
            tick();
        end
        in_valid = 1'b0;

        // Bubble collapse, then full stall with stalled output
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'd1; settle();
        check("bubble_in_ready_0", in_ready, 1);
        tick();
        in_valid = 1'b0; tick(); tick();
        in_valid = 1'b1; in_data = 8'd2; settle();
        check("bubble_in_ready_3", in_ready, 1);
        tick();
        in_valid = 1'b0; tick(); tick(); tick();
        check("bubble_occ", occ, 2);
        check("bubble_out_valid", out_valid, 1);
        check("bubble_out_data", out_data, 1);
        check("bubble_in_ready_7", in_ready, 1);
        in_valid = 1'b1; in_data = 8'd3; tick();
        in_data = 8'd4; settle();
        check("bubble_in_ready_8", in_ready, 1);
        tick();
        in_data = 8'd5; settle();
        check("full_in_ready", in_ready, 0);
        check("full_occ", occ, 4);
        check("full_out_data", out_data, 1);
        tick(); tick();
        check("stall_in_ready", in_ready, 0);
        check("stall_out_data", out_data, 1);
        check("stall_occ", occ, 4);
        out_ready = 1'b1; settle();
        check("release_in_ready", in_ready, 1);
        check("release_out_valid", out_valid, 1);
        check("release_out_data", out_data, 1);
        tick();
        in_valid = 1'b0;
        check("shift_occ", occ, 4);
        for (int w = 2; w <= 5; w++) begin
            check("drain_out_valid", out_valid, 1);
            check("drain_out_data", out_data, w);
            tick();
        end
        check("drain_empty_valid", out_valid, 0);
        check("drain_empty_occ", occ, 0);

        // Clear with both sides requesting a transfer
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int w = 1; w <= 3; w++) begin
            in_data = 8'(w);
            tick();
        end
        in_valid = 1'b0;
        tick(); tick(); tick();
        check("preclear_occ", occ, 3);
        check("preclear_out_data", out_data, 1);
        clear = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = 8'd9;
        settle();
        check("clear_in_ready", in_ready, 0);
        tick();
        clear = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
        settle();
        check("clear_occ", occ, 0);
        check("clear_out_valid", out_valid, 0);
        check("clear_out_data", out_data, 8'hA5);

        // Asynchronous reset between edges
        in_valid = 1'b1; in_data = 8'h3C; tick();
        in_valid = 1'b0; tick(); tick(); tick(); tick();
        check("pre_areset_valid", out_valid, 1);
        check("pre_areset_data", out_data, 8'h3C);
        #2;
        areset = 1'b1;
        #1;
        check("areset_out_valid", out_valid, 0);
        check("areset_occ", occ, 0);
        check("areset_out_data", out_data, 8'hA5);
        tick();
        areset = 1'b0;
        settle();
        check("post_areset_in_ready", in_ready, 1);

        // DEPTH=1 random traffic against the expected queue
        for (int c = 0; c < 400; c++) begin
            logic exp_ready;
            in1_valid  = 1'($urandom_range(0, 1));
            in1_data   = 8'($urandom_range(0, 255));
            out1_ready = 1'($urandom_range(0, 1));
            settle();
            exp_ready = (exp_q.size() == 0) || out1_ready;
            check("d1_out_valid", out1_valid, exp_q.size() > 0);
            if (exp_q.size() > 0) check("d1_out_data", out1_data, exp_q[0]);
            check("d1_in_ready", in1_ready, exp_ready);
            check("d1_occ", occ1, exp_q.size());
            if (exp_q.size() > 0 && out1_ready) void'(exp_q.pop_front());
            if (in1_valid && exp_ready) exp_q.push_back(in1_data);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
